// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared state encoding, requester ids and command record
package ram_port_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_e;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;
  typedef struct packed {
    logic       who;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;
endpackage

// File: rtl/ram_port_arbiter_arb_pick.sv
// ram_port_arbiter_arb_pick: combinational winner selection between cpu and loader
module ram_port_arbiter_arb_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int CPU_PRIORITY = 0
) (
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic last_winner,
  input  logic lock_owner,
  output logic any_req,
  output logic winner
);
  // lone requester wins; ties go to the lock holder, then fixed priority, then round-robin
  always_comb begin
    any_req = cpu_req || ldr_req;
    winner  = !ldr_req ? REQ_CPU :
              !cpu_req ? REQ_LDR :
              lock_owner ? REQ_LDR :
              (CPU_PRIORITY != 0) ? REQ_CPU : ~last_winner;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between the cpu memory path and the loader
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int RD_LAT       = 1,
  parameter int CPU_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic       cpu_rvalid,
  output logic [7:0] cpu_rdata,
  input  logic       ldr_req,
  input  logic       ldr_we,
  input  logic [7:0] ldr_addr,
  input  logic [7:0] ldr_wdata,
  input  logic       ldr_lock,
  output logic       ldr_gnt,
  output logic       ldr_rvalid,
  output logic [7:0] ldr_rdata,
  input  logic [7:0] ram_out,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_we,
  output logic       busy
);
  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [1:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       lock_q, lock_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] ldr_rdata_q, ldr_rdata_d;
  logic       any_req, winner, acc, done;

  ram_port_arbiter_arb_pick #(.CPU_PRIORITY(CPU_PRIORITY)) u_pick (
    .cpu_req    (cpu_req),
    .ldr_req    (ldr_req),
    .last_winner(last_q),
    .lock_owner (lock_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  // state, command, arbitration history and read-data holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      last_q      <= REQ_LDR;
      lock_q      <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      lock_q      <= lock_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // latch the winner in IDLE, one access cycle, then count out the read latency
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = ACCESS;
        cmd_d   = winner == REQ_LDR ? '{REQ_LDR, ldr_we, ldr_addr, ldr_wdata}
                                    : '{REQ_CPU, cpu_we, cpu_addr, cpu_wdata};
      end
      ACCESS: begin
        last_d  = cmd_q.who;
        lock_d  = cmd_q.who == REQ_LDR && ldr_lock;
        state_d = cmd_q.we ? IDLE : RD_WAIT;
        cnt_d   = 2'(RD_LAT - 1);
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM drive, grant/valid pulses and read data returned in the valid cycle
  always_comb begin
    acc         = state_q == ACCESS;
    done        = state_q == RD_WAIT && cnt_q == 2'd0;
    busy        = state_q != IDLE;
    cpu_gnt     = acc && cmd_q.who == REQ_CPU;
    ldr_gnt     = acc && cmd_q.who == REQ_LDR;
    cpu_rvalid  = done && cmd_q.who == REQ_CPU;
    ldr_rvalid  = done && cmd_q.who == REQ_LDR;
    ram_addr    = busy ? cmd_q.addr : 8'h00;
    ram_data    = busy ? cmd_q.wdata : 8'h00;
    ram_we      = acc && cmd_q.we;
    cpu_rdata_d = cpu_rvalid ? ram_out : cpu_rdata_q;
    ldr_rdata_d = ldr_rvalid ? ram_out : ldr_rdata_q;
    cpu_rdata   = cpu_rdata_d;
    ldr_rdata   = ldr_rdata_d;
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random checks of the RAM port arbiter against a transaction model
module tb_ram_port_arbiter;
  localparam int LAT = 2;
  typedef struct packed {logic we; logic [7:0] addr; logic [7:0] wdata; logic lock;} tcmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cpu_req, cpu_we, cpu_gnt, cpu_rvalid, ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid, ram_we, busy;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, ldr_addr, ldr_wdata, ldr_rdata, ram_out, ram_addr, ram_data;
  logic p_rst, p_req, p_cgnt, p_crv, p_lgnt, p_lrv, p_we, p_busy;
  logic [7:0] p_crd, p_lrd, p_addr, p_data;

  ram_port_arbiter #(.RD_LAT(LAT), .CPU_PRIORITY(0)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_lock(ldr_lock),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .ram_out(ram_out), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .busy(busy)
  );

  ram_port_arbiter #(.RD_LAT(1), .CPU_PRIORITY(1)) dut_p (
    .clk(clk), .rst(p_rst),
    .cpu_req(p_req), .cpu_we(1'b1), .cpu_addr(8'h01), .cpu_wdata(8'h11),
    .cpu_gnt(p_cgnt), .cpu_rvalid(p_crv), .cpu_rdata(p_crd),
    .ldr_req(p_req), .ldr_we(1'b1), .ldr_addr(8'h02), .ldr_wdata(8'h22), .ldr_lock(1'b0),
    .ldr_gnt(p_lgnt), .ldr_rvalid(p_lrv), .ldr_rdata(p_lrd),
    .ram_out(8'h00), .ram_addr(p_addr), .ram_data(p_data), .ram_we(p_we), .busy(p_busy)
  );

  // RAM environment: unwritten locations read as addr^5A, read data appears LAT cycles after the address
  logic [7:0]   ram [256];
  logic [255:0] wr_ok = '0;
  logic [7:0]   pipe [LAT];
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr]   <= ram_data;
      wr_ok[ram_addr] <= 1'b1;
    end
    pipe[0] <= wr_ok[ram_addr] ? ram[ram_addr] : ram_addr ^ 8'h5A;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_out = pipe[LAT-1];

  // transaction-level reference model
  logic [7:0] mdl_mem [256];
  bit         t_v, t_who, t_we, m_last, m_lock;
  int         t_start;
  logic [7:0] t_addr, t_wdata, t_rd, m_rd_c, m_rd_l;
  tcmd_t      q_cpu[$], q_ldr[$];
  int         cyc, nchk, nerr, gfirst, lg_cyc, lr_cyc, rv_count, pc, pl;
  bit         rnd_en, rst_hold, rst_rdw, p_cnt;
  logic [7:0] lr_data, cr_data;
  logic [16:0] gnt_ram;
  bit         gord[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int t_end();
    return t_start + (t_we ? 0 : LAT);
  endfunction

  function automatic bit model_busy();
    return t_v && cyc <= t_end();
  endfunction

  task automatic step();
    bit acc, done, bsy, w;
    tcmd_t c;
    @(negedge clk);
    acc  = t_v && cyc == t_start;
    done = t_v && !t_we && cyc == t_end();
    bsy  = model_busy() && cyc >= t_start;
    if (acc) begin
      if (t_we) mdl_mem[t_addr] = t_wdata;
      else t_rd = mdl_mem[t_addr];
    end
    if (done && !t_who) m_rd_c = t_rd;
    if (done && t_who) m_rd_l = t_rd;
    if (cyc >= 2) begin
      check("gnt", {cpu_gnt, ldr_gnt}, {acc && !t_who, acc && t_who});
      check("ram", {ram_addr, ram_data, ram_we}, {bsy ? t_addr : 8'h00, bsy ? t_wdata : 8'h00, acc && t_we});
      check("rvalid", {cpu_rvalid, ldr_rvalid}, {done && !t_who, done && t_who});
      check("rdata", {cpu_rdata, ldr_rdata}, {m_rd_c, m_rd_l});
      check("busy", busy, bsy);
    end
    if (acc && !t_who && q_cpu.size() != 0) void'(q_cpu.pop_front());
    if (acc && t_who && q_ldr.size() != 0) void'(q_ldr.pop_front());
    if (cpu_gnt === 1'b1) begin
      gord.push_back(1'b0);
      gnt_ram = {ram_addr, ram_data, ram_we};
      if (gfirst < 0) gfirst = cyc;
    end
    if (ldr_gnt === 1'b1) begin
      gord.push_back(1'b1);
      lg_cyc = cyc;
    end
    if (ldr_rvalid === 1'b1) begin
      lr_cyc  = cyc;
      lr_data = ldr_rdata;
    end
    if (cpu_rvalid === 1'b1) cr_data = cpu_rdata;
    if (cpu_rvalid === 1'b1 || ldr_rvalid === 1'b1) rv_count++;
    if (p_cnt) begin
      pc += int'(p_cgnt);
      pl += int'(p_lgnt);
    end
    if (rnd_en) begin
      if (q_cpu.size() == 0 && $urandom_range(0, 2) == 0)
        q_cpu.push_back('{1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom), 1'b0});
      if (q_ldr.size() == 0 && $urandom_range(0, 2) == 0)
        q_ldr.push_back('{1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom),
                          1'($urandom_range(0, 3) == 0)});
    end
    rst = rst_hold || (rnd_en && $urandom_range(0, 149) == 0);
    if (rst_rdw && t_v && !t_we && cyc == t_start + 1) begin
      rst     = 1'b1;
      rst_rdw = 1'b0;
    end
    c = q_cpu.size() != 0 ? q_cpu[0] : '0;
    cpu_req = q_cpu.size() != 0;
    {cpu_we, cpu_addr, cpu_wdata} = {c.we, c.addr, c.wdata};
    c = q_ldr.size() != 0 ? q_ldr[0] : '0;
    ldr_req = q_ldr.size() != 0;
    {ldr_we, ldr_addr, ldr_wdata, ldr_lock} = {c.we, c.addr, c.wdata, c.lock};
    if (rst) begin
      t_v    = 1'b0;
      m_last = 1'b1;
      m_lock = 1'b0;
      m_rd_c = 8'h00;
      m_rd_l = 8'h00;
    end else begin
      if (acc) begin
        m_last = t_who;
        m_lock = t_who && ldr_lock;
      end
      if (!model_busy() && (cpu_req || ldr_req)) begin
        if (!ldr_req) w = 1'b0;
        else if (!cpu_req) w = 1'b1;
        else if (m_lock) w = 1'b1;
        else w = !m_last;
        t_v     = 1'b1;
        t_who   = w;
        t_start = cyc + 1;
        {t_we, t_addr, t_wdata} = w ? {ldr_we, ldr_addr, ldr_wdata} : {cpu_we, cpu_addr, cpu_wdata};
      end
    end
    cyc++;
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((q_cpu.size() != 0 || q_ldr.size() != 0 || model_busy()) && n < max) begin
      step();
      n++;
    end
    check("drain", {31'd0, q_cpu.size() != 0 || q_ldr.size() != 0 || model_busy()}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'(i) ^ 8'h5A;
    {cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock} = '0;
    {t_v, t_who, t_we, m_lock, rnd_en, rst_rdw, p_cnt, p_req} = '0;
    m_last = 1'b1; t_start = 0; t_addr = 0; t_wdata = 0; t_rd = 0; m_rd_c = 0; m_rd_l = 0;
    cyc = 0; nchk = 0; nerr = 0; gfirst = -1; lg_cyc = 0; lr_cyc = 0; rv_count = 0; pc = 0; pl = 0;
    lr_data = 0; cr_data = 0; gnt_ram = 0;
    rst = 1'b1; rst_hold = 1'b1; p_rst = 1'b1;
    q_cpu.push_back('{1'b1, 8'h10, 8'hA5, 1'b0});
    repeat (4) step();
    rst_hold = 1'b0;
    run_idle(20);
    check("rst_to_gnt", gfirst - 4, 1);
    check("wr10", {15'd0, gnt_ram}, {15'd0, 8'h10, 8'hA5, 1'b1});
    q_ldr.push_back('{1'b0, 8'h10, 8'h00, 1'b0});
    run_idle(20);
    check("ldr_rd", lr_data, 8'hA5);
    check("ldr_lat", lr_cyc - lg_cyc, LAT);
    gord.delete();
    repeat (2) begin
      q_cpu.push_back('{1'b1, 8'h20, 8'h01, 1'b0});
      q_ldr.push_back('{1'b1, 8'h21, 8'h02, 1'b0});
    end
    run_idle(40);
    check("rr_n", gord.size(), 4);
    if (gord.size() >= 4) check("rr_order", {gord[0], gord[1], gord[2], gord[3]}, 4'b0101);
    gord.delete();
    for (int i = 0; i < 3; i++) q_ldr.push_back('{1'b1, 8'(i), 8'hC0 + 8'(i), 1'b1});
    step();
    q_cpu.push_back('{1'b1, 8'h30, 8'h77, 1'b0});
    run_idle(40);
    check("lock_n", gord.size(), 4);
    if (gord.size() >= 4) check("lock_order", {gord[0], gord[1], gord[2], gord[3]}, 4'b1110);
    rv_count = 0;
    rst_rdw  = 1'b1;
    q_cpu.push_back('{1'b0, 8'h33, 8'h00, 1'b0});
    run_idle(20);
    check("abort_rv", rv_count, 0);
    q_cpu.push_back('{1'b0, 8'hFF, 8'h00, 1'b0});
    run_idle(20);
    check("rd_ff", cr_data, 8'hA5);
    check("rd_ff_rv", rv_count, 1);
    p_rst = 1'b0;
    p_req = 1'b1;
    p_cnt = 1'b1;
    repeat (20) step();
    p_cnt = 1'b0;
    p_req = 1'b0;
    check("prio_cpu", pc, 10);
    check("prio_ldr", pl, 0);
    rnd_en = 1'b1;
    repeat (800) step();
    rnd_en = 1'b0;
    run_idle(200);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
